str_interp: RTL and testbench

STR_INTERP -- requirements
Module: str_interp

---
 rtl/str_interp.sv | 53 +++++
 tb/tb_str_interp.sv | 120 ++++++++++++
 2 files changed

// File: rtl/str_interp.sv
// str_interp: streaming interpolator, emits INTERP beats per accepted sample
// with zero-stuffing (HOLD=0) or sample-and-hold (HOLD=1) fill.
module str_interp #(
    parameter int DW     = 10,
    parameter int INTERP = 5,
    parameter int HOLD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] in,
    input  logic                 ivalid,
    output logic                 iready,
    output logic signed [DW-1:0] out,
    output logic                 ovalid,
    input  logic                 oready,
    output logic                 ofirst
);
    localparam int PW = INTERP > 1 ? $clog2(INTERP) : 1;
    typedef enum logic {IDLE, EMIT} state_t;
    state_t        state;
    logic [PW-1:0] phase;
    logic          last, ish, osh;
    assign ovalid = state == EMIT;
    assign last   = phase == PW'(INTERP - 1);
    assign iready = ~ovalid | (oready & last);
    assign ish    = ivalid & iready;
    assign osh    = ovalid & oready;
    // A new sample always wins, so the last beat of a group and the next
    // load share one cycle and groups run back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            out    <= '0;
            ofirst <= 1'b0;
            phase  <= '0;
        end else if (ish) begin
            state  <= EMIT;
            out    <= in;
            ofirst <= 1'b1;
            phase  <= '0;
        end else if (osh) begin
            ofirst <= 1'b0;
            if (last) begin
                state <= IDLE;
                out   <= '0;
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
                if (HOLD == 0) out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_str_interp.sv
// tb_str_interp: three configurations (zero-stuff, hold, pass-through) checked
// by a queue scoreboard fed from observed input handshakes.
module tb_str_interp;
    localparam int DW = 10;
    logic                 clk = 0, rst_n = 0;
    logic signed [DW-1:0] in_s   [3];
    logic                 ivalid [3];
    logic                 iready [3];
    logic signed [DW-1:0] out_s  [3];
    logic                 ovalid [3];
    logic                 oready [3];
    logic                 ofirst [3];
    logic [DW:0]          q      [3][$];
    logic                 stall_v[3];
    logic [DW:0]          stall_d[3];
    int n_cmp = 0, n_bad = 0;
    bit rnd = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        str_interp #(.DW(DW), .INTERP(g == 2 ? 1 : 5), .HOLD(g == 1 ? 1 : 0)) u (
            .clk(clk), .rst_n(rst_n), .in(in_s[g]), .ivalid(ivalid[g]), .iready(iready[g]),
            .out(out_s[g]), .ovalid(ovalid[g]), .oready(oready[g]), .ofirst(ofirst[g]));
    end
    function automatic int interp_of(int k); return k == 2 ? 1 : 5; endfunction
    function automatic bit hold_of(int k); return k == 1; endfunction
    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask
    // Monitor/scoreboard: compare against queued beats, then enqueue new groups.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                q[k].delete();
                stall_v[k] = 0;
                chk("reset", k, {ovalid[k], ofirst[k], out_s[k]}, 0);
            end else begin
                chk("iready", k, iready[k], q[k].size() == 0 || (oready[k] && q[k].size() == 1));
                chk("ovalid", k, ovalid[k], q[k].size() != 0);
                if (!ovalid[k]) chk("idle_out", k, {ofirst[k], out_s[k]}, 0);
                if (stall_v[k]) chk("stall", k, {ovalid[k], ofirst[k], out_s[k]}, {1'b1, stall_d[k]});
                if (ovalid[k] && oready[k] && q[k].size() != 0)
                    chk("beat", k, {ofirst[k], out_s[k]}, q[k].pop_front());
                stall_v[k] = ovalid[k] && !oready[k];
                stall_d[k] = {ofirst[k], out_s[k]};
                if (ivalid[k] && iready[k]) begin
                    q[k].push_back({1'b1, in_s[k]});
                    for (int p = 1; p < interp_of(k); p++)
                        q[k].push_back({1'b0, hold_of(k) ? in_s[k] : {DW{1'b0}}});
                end
            end
        end
    end
    initial begin
        for (int k = 0; k < 3; k++) oready[k] = 1;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) oready[k] = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end
    // Called at posedge+1; returns at posedge+1 just after the sample is taken.
    task automatic send(int k, int v, bit garb);
        int n = 0;
        in_s[k] = v[DW-1:0];
        ivalid[k] = 1;
        forever begin
            @(negedge clk);
            if (iready[k]) break;
            if (garb) in_s[k] = DW'($urandom);
            if (++n > 200) begin
                chk("send_timeout", k, 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        ivalid[k] = 0;
    endtask
    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 0, 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin ivalid[k] = 0; in_s[k] = '0; end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        send(0, 7, 0); drain();
        send(1, -3, 0); drain();
        send(0, 1, 0); send(0, 2, 0); drain();
        send(2, 4, 0); send(2, 5, 0); send(2, 6, 0); drain();
        send(0, 5, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0;
        #1 chk("async_rst", 0, {ovalid[0], ofirst[0], out_s[0]}, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1;
        repeat (4) begin @(posedge clk); #1; end
        send(0, 9, 0); drain();
        rnd = 1;
        for (int k = 0; k < 3; k++) begin
            repeat (40) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send(k, int'($urandom), 1);
            end
            drain();
        end
        rnd = 0;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
